xcore_demux4_rx: RTL and testbench
==================================

// Module: xcore_demux4_rx
// PURPOSE
//   Receive-side counterpart of the Xcore 4:1 line mux. Samples the shared serial line on
//   sample_en strobes and routes each bit to lane {scl,dir_en} (0..3), the same select
//   mapping the transmit mux uses. Deserialises each lane into DATA_W-bit words and
//   round-robin arbitrates completed words onto one valid/ready output tagged with the lane.
// PARAMETERS
//   DATA_W     8   bits per word per lane (2..32)
//   MSB_FIRST  1   1: first received bit lands in out_data[DATA_W-1]; 0: in out_data[0]
// PORTS
//   clk        in   1       system clock, all logic on rising edge
//   rst        in   1       synchronous reset, active-high
//   din        in   1       shared serial line (mux output)
//   scl        in   1       lane select bit 1
//   dir_en     in   1       lane select bit 0
//   sample_en  in   1       one-cycle strobe: din is a valid bit for lane {scl,dir_en}
//   out_ready  in   1       downstream accepts word
//   out_valid  out  1       out_data/out_lane hold a completed word
//   out_data   out  DATA_W  assembled word
//   out_lane   out  2       lane index of out_data
//   ovf        out  4       sticky per-lane overflow flags
//   ovf_clr    in   4       one-cycle per-lane clear of ovf
// BEHAVIOUR
//   Reset: out_valid=0, out_data=0, out_lane=0, ovf=0; all shifters, bit counters and
//     hold registers cleared; round-robin pointer = lane 0. Reset mid-word discards partials.
//   Per lane: shifter[DATA_W], cnt[0..DATA_W-1], hold[DATA_W] + hold_v.
//   sample_en=1: lane L={scl,dir_en} shifts din in (direction per MSB_FIRST), cnt++.
//     Other lanes untouched. sample_en=0: no lane changes; scl/dir_en ignored.
//   Word completes on the strobe with cnt==DATA_W-1: cnt->0, word moves to hold[L] at
//     the next edge if hold_v[L]=0 or hold[L] is granted the same cycle; otherwise the
//     word is dropped, ovf[L] set, and hold[L] keeps the older word.
//   Output stage is one register: load when out_valid=0 or (out_valid & out_ready).
//     Grant goes to the first lane with hold_v=1 searching from ptr+1 (mod 4) upward;
//     ptr <= granted lane; hold_v[granted] cleared the same edge.
//   Latency: last-bit strobe at edge t -> hold_v at t+1 -> out_valid at t+2 (output free).
//   Back-to-back: out_valid held high across transfers, one word per cycle when ready=1.
//   out_valid/out_data/out_lane stable while out_valid & !out_ready.
//   ovf: set has priority over ovf_clr in the same cycle for the same lane.
//   No valid lane holds a word: out_valid drops after the handshake cycle.
// TESTING
//   1 Reset: rst=1 two cycles with strobes active -> all outputs 0, no out_valid.
//   2 Lane 3 (scl=1,dir_en=1), DATA_W=8, bits 1,0,1,0,0,1,0,1 MSB first, ready=1 ->
//     one word out_data=8'hA5, out_lane=3, out_valid exactly 2 cycles after last strobe.
//   3 Interleave strobes lane1/lane2 bit-by-bit (lane1 8'h0F, lane2 8'hF0) -> two words,
//     correct lane tags, no cross-lane corruption.
//   4 All four lanes complete same region with ready=0, then ready=1 -> four words lanes
//     1,2,3,0 (ptr starts 0), one per cycle, out stable while ready=0.
//   5 ready=0, lane 0 sends three words -> first in out reg, second in hold, third dropped,
//     ovf=4'b0001; ovf_clr=4'b0001 -> ovf=0; concurrent set+clr -> ovf stays 1.
//   6 rst asserted after 5 bits on lane 2 -> then 8 fresh bits 8'h3C -> out_data=8'h3C.

Source files
------------

// File: rtl/xcore_demux4_rx.sv
// Receive side of the Xcore 4:1 line mux: routes sampled bits to four lane
// deserialisers and round-robin arbitrates completed words onto one output.
module xcore_demux4_rx #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              scl,
  input  logic              dir_en,
  input  logic              sample_en,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_lane,
  output logic [3:0]        ovf,
  input  logic [3:0]        ovf_clr
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] shift_reg [4];
  logic [CW-1:0]     cnt_reg   [4];
  logic [DATA_W-1:0] hold_reg  [4];
  logic [3:0]        hold_v_reg;
  logic [1:0]        ptr_reg;

  logic [1:0]        sel_lane;
  logic              load;
  logic              grant_v;
  logic [1:0]        grant_lane;
  logic [1:0]        scan_idx;
  logic              grant_fire;

  logic [DATA_W-1:0] shifted [4];
  logic [3:0]        strobe;
  logic [3:0]        done;
  logic [3:0]        freed;
  logic [3:0]        accept;
  logic [3:0]        drop;

  assign sel_lane   = {scl, dir_en};
  assign load       = !out_valid || out_ready;
  assign grant_fire = grant_v && load;

  // Scan from ptr+4 (=ptr) down to ptr+1 so the nearest lane after ptr wins.
  always_comb begin
    grant_v    = 1'b0;
    grant_lane = ptr_reg;
    scan_idx   = ptr_reg;
    for (int i = 4; i >= 1; i--) begin
      scan_idx = ptr_reg + 2'(i);
      if (hold_v_reg[scan_idx]) begin
        grant_v    = 1'b1;
        grant_lane = scan_idx;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign strobe[gi]  = sample_en && (sel_lane == 2'(gi));
      assign shifted[gi] = MSB_FIRST ? {shift_reg[gi][DATA_W-2:0], din}
                                     : {din, shift_reg[gi][DATA_W-1:1]};
      assign done[gi]    = strobe[gi] && (cnt_reg[gi] == CW'(DATA_W - 1));
      // A hold slot being granted this cycle can take the new word immediately.
      assign freed[gi]   = grant_fire && (grant_lane == 2'(gi));
      assign accept[gi]  = done[gi] && (!hold_v_reg[gi] || freed[gi]);
      assign drop[gi]    = done[gi] && hold_v_reg[gi] && !freed[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        shift_reg[i] <= '0;
        cnt_reg[i]   <= '0;
        hold_reg[i]  <= '0;
      end
      hold_v_reg <= '0;
      ptr_reg    <= '0;
      ovf        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_lane   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (strobe[i]) begin
          shift_reg[i] <= shifted[i];
          cnt_reg[i]   <= done[i] ? '0 : cnt_reg[i] + 1'b1;
        end
        if (accept[i]) begin
          hold_reg[i] <= shifted[i];
        end
        hold_v_reg[i] <= accept[i] | (hold_v_reg[i] & ~freed[i]);
        ovf[i]        <= drop[i] | (ovf[i] & ~ovf_clr[i]);
      end
      if (grant_fire) begin
        out_valid <= 1'b1;
        out_data  <= hold_reg[grant_lane];
        out_lane  <= grant_lane;
        ptr_reg   <= grant_lane;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xcore_demux4_rx.sv
// Directed bench for xcore_demux4_rx: lane routing, latency, round-robin order,
// overflow handling and mid-word reset, with hand-computed expectations.
module tb_xcore_demux4_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       scl;
  logic       dir_en;
  logic       sample_en;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_lane;
  logic [3:0] ovf;
  logic [3:0] ovf_clr;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  xcore_demux4_rx #(.DATA_W(8), .MSB_FIRST(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .scl       (scl),
    .dir_en    (dir_en),
    .sample_en (sample_en),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic [1:0] lane, input logic b);
    sample_en = 1'b1;
    scl       = lane[1];
    dir_en    = lane[0];
    din       = b;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic send_word(input logic [1:0] lane, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(lane, w[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] w4 [4];
    logic [1:0] order [4];
    rst = 1'b1; din = 1'b1; scl = 1'b1; dir_en = 1'b1; sample_en = 1'b1;
    out_ready = 1'b1; ovf_clr = 4'b0000;

    // 1: reset held two cycles with strobes active
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_lane", out_lane, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0; sample_en = 1'b0;
    tick();
    check("rst_after_valid", out_valid, 0);

    // 2: lane 3, 8'hA5, two-cycle latency
    send_word(2'd3, 8'hA5);
    check("lat_t1_valid", out_valid, 0);
    tick();
    check("lat_t2_valid", out_valid, 1);
    check("lat_data", out_data, 8'hA5);
    check("lat_lane", out_lane, 3);
    tick();
    check("lat_drop_valid", out_valid, 0);

    // 3: interleaved lanes 1 and 2
    for (int i = 7; i >= 0; i--) begin
      send_bit(2'd1, 1'((8'h0F >> i) & 8'h01));
      send_bit(2'd2, 1'((8'hF0 >> i) & 8'h01));
    end
    check("il_w1_valid", out_valid, 1);
    check("il_w1_lane", out_lane, 1);
    check("il_w1_data", out_data, 8'h0F);
    tick();
    check("il_w2_valid", out_valid, 1);
    check("il_w2_lane", out_lane, 2);
    check("il_w2_data", out_data, 8'hF0);
    tick();
    check("il_end_valid", out_valid, 0);

    // 4: four lanes with ready low, then drained in round-robin order
    do_reset();
    out_ready = 1'b0;
    w4[0] = 8'h81; w4[1] = 8'h42; w4[2] = 8'h24; w4[3] = 8'h18;
    for (int i = 7; i >= 0; i--) begin
      send_bit(2'd1, w4[1][i]);
      send_bit(2'd2, w4[2][i]);
      send_bit(2'd3, w4[3][i]);
      send_bit(2'd0, w4[0][i]);
    end
    tick(); tick();
    check("rr_stall_valid", out_valid, 1);
    check("rr_stall_lane", out_lane, 1);
    check("rr_stall_data", out_data, 8'h42);
    order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd3; order[3] = 2'd0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr%0d_valid", k), out_valid, 1);
      check($sformatf("rr%0d_lane", k), out_lane, order[k]);
      check($sformatf("rr%0d_data", k), out_data, w4[order[k]]);
      out_ready = 1'b1;
      tick();
    end
    check("rr_end_valid", out_valid, 0);

    // 5: lane 0 overflow, clear, and set-beats-clear
    do_reset();
    out_ready = 1'b0;
    send_word(2'd0, 8'h11);
    tick();
    send_word(2'd0, 8'h22);
    check("ovf_none", ovf, 4'b0000);
    send_word(2'd0, 8'h33);
    check("ovf_set", ovf, 4'b0001);
    check("ovf_out_kept", out_data, 8'h11);
    ovf_clr = 4'b0001;
    tick();
    ovf_clr = 4'b0000;
    check("ovf_clr", ovf, 4'b0000);
    for (int i = 7; i >= 1; i--) send_bit(2'd0, 1'((8'h44 >> i) & 8'h01));
    ovf_clr = 4'b0001;
    send_bit(2'd0, 1'b0);
    ovf_clr = 4'b0000;
    check("ovf_set_over_clr", ovf, 4'b0001);
    check("ovf_hold_out_valid", out_valid, 1);
    check("ovf_hold_out_data", out_data, 8'h11);
    out_ready = 1'b1;
    tick();
    check("ovf_second_valid", out_valid, 1);
    check("ovf_second_data", out_data, 8'h22);
    tick();
    check("ovf_drain_valid", out_valid, 0);

    // 6: reset mid-word discards the partial
    do_reset();
    for (int i = 0; i < 5; i++) send_bit(2'd2, 1'b1);
    do_reset();
    send_word(2'd2, 8'h3C);
    tick();
    check("midrst_valid", out_valid, 1);
    check("midrst_data", out_data, 8'h3C);
    check("midrst_lane", out_lane, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
